coproc_cmd_issuer: RTL and testbench

COPROC_CMD_ISSUER -- requirements
Module: coproc_cmd_issuer

---
 rtl/coproc_cmd_pkg.sv | 28 ++
 rtl/coproc_cmd_issuer_fifo.sv | 71 +++++++
 rtl/coproc_cmd_issuer.sv | 139 +++++++++++++
 tb/tb_coproc_cmd_issuer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coproc_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : coproc_cmd_pkg
// Purpose  : Shared command type, FSM state encoding and widths for the
//            coprocessor command issuer.
// Revision : 1.0 - initial release
// ============================================================================
package coproc_cmd_pkg;

    localparam int c_FUNC_W     = 3;
    localparam int c_CMD_W      = 5;
    localparam int c_DONE_CNT_W = 8;
    localparam int c_WAIT_CNT_W = 20;

    typedef struct packed {
        logic                img_idx;
        logic                gray;
        logic [c_FUNC_W-1:0] func;
    } coproc_cmd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } issuer_state_t;

endpackage
`default_nettype wire

// File: rtl/coproc_cmd_issuer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cmd_fifo
// Purpose  : Power-of-two command FIFO; a push while full is accepted only
//            when a pop happens on the same edge, otherwise it is dropped.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_fifo
    import coproc_cmd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [c_CMD_W-1:0]       wdata,
    input  logic                     pop,
    output logic [c_CMD_W-1:0]       rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int              c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL_CNT = (c_AW + 1)'(DEPTH);

    coproc_cmd_t        r_mem [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_AW:0]      r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == c_FULL_CNT);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign drop      = push && !w_do_push;
    assign rdata     = r_mem[r_rd_ptr];

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= coproc_cmd_t'(wdata);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/coproc_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : coproc_cmd_issuer
// Purpose  : Queues coprocessor commands and issues them one at a time with a
//            start pulse, waiting for done or aborting on timeout.
// Revision : 1.0 - initial release
// ============================================================================
module coproc_cmd_issuer
    import coproc_cmd_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1048576
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_we,
    input  logic [c_CMD_W-1:0]          cmd_wdata,
    input  logic                        err_clr,
    output logic                        cmd_full,
    output logic [$clog2(DEPTH):0]      cmd_count,
    output logic                        busy,
    output logic                        ovf,
    output logic                        timeout,
    output logic [c_DONE_CNT_W-1:0]     done_cnt,
    output logic                        start_n,
    output logic [c_FUNC_W-1:0]         func,
    output logic                        gray,
    output logic                        img_idx,
    input  logic                        rdy,
    input  logic                        done
);

    localparam logic [c_WAIT_CNT_W-1:0] c_WAIT_LAST = c_WAIT_CNT_W'(TIMEOUT - 1);

    issuer_state_t              r_state;
    logic                       r_push;
    logic [c_CMD_W-1:0]         r_wdata;
    logic                       r_err_clr;
    logic [c_WAIT_CNT_W-1:0]    r_wait_cnt;
    coproc_cmd_t                w_head;
    logic                       w_empty;
    logic                       w_drop;
    logic                       w_launch;
    logic                       w_wait_last;

    // Host writes and clears pass through one register stage together, so a
    // clear and a push issued on the same edge also meet on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_push    <= 1'b0;
            r_wdata   <= '0;
            r_err_clr <= 1'b0;
        end else begin
            r_push    <= cmd_we;
            r_wdata   <= cmd_wdata;
            r_err_clr <= err_clr;
        end
    end

    cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (r_push),
        .wdata (r_wdata),
        .pop   (w_launch),
        .rdata (w_head),
        .full  (cmd_full),
        .empty (w_empty),
        .count (cmd_count),
        .drop  (w_drop)
    );

    assign w_launch    = (r_state == IDLE) && !w_empty && rdy;
    assign w_wait_last = (r_wait_cnt == c_WAIT_LAST);
    assign busy        = (r_state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (w_drop) begin
            ovf <= 1'b1;
        end else if (r_err_clr) begin
            ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            start_n    <= 1'b1;
            func       <= '0;
            gray       <= 1'b0;
            img_idx    <= 1'b0;
            done_cnt   <= '0;
            timeout    <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            // Clear first so a timeout set later in this block takes priority.
            if (r_err_clr) begin
                timeout <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        r_state <= LAUNCH;
                        start_n <= 1'b0;
                        func    <= w_head.func;
                        gray    <= w_head.gray;
                        img_idx <= w_head.img_idx;
                    end
                end
                LAUNCH: begin
                    r_state    <= WAIT;
                    start_n    <= 1'b1;
                    r_wait_cnt <= '0;
                end
                WAIT: begin
                    if (done) begin
                        r_state  <= IDLE;
                        done_cnt <= done_cnt + 1'b1;
                    end else if (w_wait_last) begin
                        r_state <= IDLE;
                        timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    start_n <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_coproc_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_coproc_cmd_issuer
// Purpose  : Scoreboard bench for coproc_cmd_issuer: stimulus queues expected
//            launches and responses, a monitor checks them as they appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coproc_cmd_issuer;

    localparam int c_DEPTH = 4;
    localparam int c_TO    = 64;
    localparam int c_NONE  = 1000;   // response delay meaning "never send done"

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_we = 1'b0;
    logic [4:0] cmd_wdata = '0;
    logic       err_clr = 1'b0;
    logic       cmd_full;
    logic [2:0] cmd_count;
    logic       busy;
    logic       ovf;
    logic       timeout;
    logic [7:0] done_cnt;
    logic       start_n;
    logic [2:0] func;
    logic       gray;
    logic       img_idx;
    logic       rdy = 1'b0;
    logic       done = 1'b0;

    coproc_cmd_issuer #(
        .DEPTH   (c_DEPTH),
        .TIMEOUT (c_TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_we    (cmd_we),
        .cmd_wdata (cmd_wdata),
        .err_clr   (err_clr),
        .cmd_full  (cmd_full),
        .cmd_count (cmd_count),
        .busy      (busy),
        .ovf       (ovf),
        .timeout   (timeout),
        .done_cnt  (done_cnt),
        .start_n   (start_n),
        .func      (func),
        .gray      (gray),
        .img_idx   (img_idx),
        .rdy       (rdy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [4:0] exp_q[$];
    int         dly_q[$];
    int         m_done_cnt = 0;
    int         m_total    = 0;
    bit         m_timeout  = 1'b0;
    bit         m_ovf      = 1'b0;
    int         exp_lat_cyc = -1;
    bit         mon_en   = 1'b1;
    bit         mon_busy = 1'b0;
    bit         rnd_rdy  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_cmd(input logic [4:0] w, input int dly, input bit accepted);
        cmd_we    = 1'b1;
        cmd_wdata = w;
        if (accepted) begin
            exp_q.push_back(w);
            dly_q.push_back(dly);
        end
        @(negedge clk);
        cmd_we = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || mon_busy || busy) && n < budget) begin
            @(negedge clk);
            if (rnd_rdy) rdy = ($urandom_range(0, 3) != 0);
            n++;
        end
        rdy = 1'b1;
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL idle_wait: queue=%0d busy=%0d after %0d cycles", exp_q.size(), busy, n);
        end
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        m_ovf     = 1'b0;
        m_timeout = 1'b0;
        chk("clr_ovf", 32'(ovf), 32'(0));
        chk("clr_timeout", 32'(timeout), 32'(0));
    endtask

    // Monitor / coprocessor responder
    initial begin
        logic [4:0] e;
        int d;
        forever begin
            @(negedge clk);
            if (mon_en && !start_n) begin
                mon_busy = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("spurious_launch", 32'(start_n), 32'(1));
                end else begin
                    e = exp_q.pop_front();
                    d = dly_q.pop_front();
                    chk("launch_cmd", 32'({img_idx, gray, func}), 32'(e));
                    if (exp_lat_cyc >= 0) begin
                        chk("launch_latency", 32'(cyc), 32'(exp_lat_cyc));
                        exp_lat_cyc = -1;
                    end
                    @(negedge clk);
                    chk("start_width", 32'(start_n), 32'(1));
                    if (d < c_TO) begin
                        repeat (d) @(negedge clk);
                        done = 1'b1;
                        @(negedge clk);
                        done = 1'b0;
                        m_done_cnt = (m_done_cnt + 1) % 256;
                        m_total++;
                    end else begin
                        repeat (c_TO) @(negedge clk);
                        m_timeout = 1'b1;
                    end
                    chk("end_busy", 32'(busy), 32'(0));
                    chk("end_done_cnt", 32'(done_cnt), 32'(m_done_cnt));
                    chk("end_timeout", 32'(timeout), 32'(m_timeout));
                    chk("end_fields_hold", 32'({img_idx, gray, func}), 32'(e));
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] w;
        int k;
        int d;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_start_n", 32'(start_n), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_count", 32'(cmd_count), 32'(0));
        chk("rst_full", 32'(cmd_full), 32'(0));
        chk("rst_done_cnt", 32'(done_cnt), 32'(0));
        chk("rst_flags", 32'({ovf, timeout}), 32'(0));
        chk("rst_fields", 32'({img_idx, gray, func}), 32'(0));

        // Single command: launch two edges after the push edge, done later
        rdy = 1'b1;
        exp_lat_cyc = cyc + 3;
        push_cmd(5'b00111, 50, 1'b1);
        wait_idle(500);
        chk("basic_done_cnt", 32'(done_cnt), 32'(1));

        // done while idle is ignored
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        chk("idle_done_ignored", 32'(done_cnt), 32'(m_done_cnt));

        // Overflow: five pushes into a depth-4 FIFO while not ready
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w = 5'($urandom_range(0, 31));
            push_cmd(w, $urandom_range(0, 5), i < c_DEPTH);
        end
        repeat (3) @(negedge clk);
        m_ovf = 1'b1;
        chk("ovf_count", 32'(cmd_count), 32'(c_DEPTH));
        chk("ovf_full", 32'(cmd_full), 32'(1));
        chk("ovf_flag", 32'(ovf), 32'(m_ovf));
        chk("ovf_no_launch", 32'(busy), 32'(0));
        rdy = 1'b1;
        wait_idle(500);
        clear_errs();

        // Push meeting the launch pop while full is kept
        rdy = 1'b0;
        for (int i = 0; i < c_DEPTH; i++) push_cmd(5'($urandom_range(0, 31)), 1, 1'b1);
        repeat (2) @(negedge clk);
        push_cmd(5'b10101, 2, 1'b1);
        rdy = 1'b1;
        @(negedge clk);
        chk("full_pop_push_count", 32'(cmd_count), 32'(c_DEPTH));
        chk("full_pop_push_ovf", 32'(ovf), 32'(0));
        wait_idle(500);

        // Timeout, then the next queued command still launches
        push_cmd(5'b01010, c_NONE, 1'b1);
        push_cmd(5'b11001, 3, 1'b1);
        wait_idle(1000);
        chk("timeout_sticky", 32'(timeout), 32'(1));
        clear_errs();

        // done exactly on the last wait cycle wins over timeout
        push_cmd(5'b00110, c_TO - 1, 1'b1);
        wait_idle(500);
        chk("coincide_timeout", 32'(timeout), 32'(0));

        // err_clr on the same edge as a dropped push leaves ovf set
        rdy = 1'b0;
        for (int i = 0; i < c_DEPTH; i++) push_cmd(5'($urandom_range(0, 31)), 0, 1'b1);
        err_clr = 1'b1;
        push_cmd(5'b11111, 0, 1'b0);
        err_clr = 1'b0;
        repeat (2) @(negedge clk);
        m_ovf = 1'b1;
        chk("ovf_set_wins", 32'(ovf), 32'(m_ovf));
        rdy = 1'b1;
        wait_idle(500);
        clear_errs();

        // Randomized bursts with random rdy and response delays
        rnd_rdy = 1'b1;
        for (int b = 0; b < 20; b++) begin
            k = $urandom_range(1, c_DEPTH);
            for (int i = 0; i < k; i++) begin
                case ($urandom_range(0, 9))
                    0:       d = c_NONE;
                    1:       d = c_TO - 1;
                    default: d = $urandom_range(0, 10);
                endcase
                push_cmd(5'($urandom_range(0, 31)), d, 1'b1);
            end
            wait_idle(2000);
        end
        rnd_rdy = 1'b0;
        chk("rand_timeout_model", 32'(timeout), 32'(m_timeout));
        clear_errs();

        // Drive completions until the counter wraps
        while (m_total < 256 || m_done_cnt != 0) begin
            push_cmd(5'($urandom_range(0, 31)), 0, 1'b1);
            wait_idle(200);
            if (errors > 50) break;
        end
        chk("done_cnt_wrap", 32'(done_cnt), 32'(0));

        // Reset while waiting with two commands queued
        mon_en = 1'b0;
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) push_cmd(5'b00001 + 5'(i), c_NONE, 1'b0);
        k = 0;
        while (start_n && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rst_test_launch_seen", 32'(start_n), 32'(0));
        @(negedge clk);
        chk("rst_test_queued", 32'(cmd_count), 32'(2));
        chk("rst_test_busy", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("arst_start_n", 32'(start_n), 32'(1));
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_count", 32'(cmd_count), 32'(0));
        chk("arst_done_cnt", 32'(done_cnt), 32'(0));
        chk("arst_flags", 32'({ovf, timeout}), 32'(0));
        chk("arst_fields", 32'({img_idx, gray, func}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        m_done_cnt = 0;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!start_n || cmd_count != 0) k++;
        end
        chk("post_rst_quiet", 32'(k), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
